window_allocator: RTL
=====================

WINDOW_ALLOCATOR -- requirements
Module: window_allocator

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, pixel read address width.
REQ-002 SHALL have parameter ACC_W, default 21, signed accumulator and result width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port select  input  1  one allocator_select bit from the issue positioner.
REQ-006 SHALL have ports center_x, center_y  input  8 each  window centre in padded-image coordinates.
REQ-007 SHALL have port image_dim  input  8  padded image side length.
REQ-008 SHALL have port padding  input  2  border width.
REQ-009 SHALL have port weights  input  72  nine signed 8-bit taps; tap k is at bits [8k+7:8k], k = 3*(dy+1)+(dx+1).
REQ-010 SHALL have port busy  output  1  high when not IDLE.
REQ-011 SHALL have ports rd_req (output, 1), rd_addr (output, ADDR_W), rd_ack (input, 1) and rd_data (input, 8, unsigned; valid when rd_ack is high).
REQ-012 SHALL have ports result (output, ACC_W, signed), result_valid (output, 1) and result_ready (input, 1).
REQ-013 SHALL have port overrun  output  1  sticky flag for a select received while busy.

Function
REQ-014 SHALL implement three states: IDLE, FETCH and DONE.
REQ-015 In IDLE with select=1, SHALL latch center_x, center_y, image_dim, padding and weights, clear the accumulator, set tap index to 0 and go to FETCH.
REQ-016 SHALL visit taps in row-major order, dy = -1..1 outer and dx = -1..1 inner, at coordinate (cx+dx, cy+dy).
REQ-017 SHALL treat a tap as padded when either coordinate c satisfies c < padding or c >= image_dim - padding, using 9-bit signed arithmetic so that cx-1 with cx=0 counts as padded.
REQ-018 A padded tap SHALL contribute zero, SHALL NOT assert rd_req, and SHALL take exactly one cycle.
REQ-019 For a non-padded tap, SHALL set rd_addr = (y-padding)*(image_dim-2*padding) + (x-padding), truncated to ADDR_W.
REQ-020 SHALL hold rd_req high with rd_addr stable until the cycle in which rd_ack=1, and SHALL have at most one read outstanding.
REQ-021 On rd_ack, SHALL add the product of zero-extended rd_data and the signed weight to the accumulator, then advance to the next tap.
REQ-022 With rd_ack tied high, SHALL complete each tap in one cycle: select sampled at cycle N gives taps at N+1..N+9 and result_valid high at N+10.
REQ-023 After tap 8 completes, SHALL enter DONE with result_valid=1 and result holding the accumulator.
REQ-024 In DONE, SHALL hold result stable until result_valid && result_ready, then return to IDLE on the next cycle.
REQ-025 SHALL accept select only in IDLE; select in FETCH or DONE SHALL be ignored, and the latched operands SHALL be unchanged.
REQ-026 SHALL drive rd_req only in FETCH and result_valid only in DONE.

Reset
REQ-027 SHALL, on any clock edge with rst=1 and in any state, go to IDLE with busy=0, rd_req=0, rd_addr=0, result_valid=0, result=0 and overrun=0.
REQ-028 SHALL discard any in-flight read on reset, and SHALL ignore an rd_ack arriving in the cycle after reset.

Configuration
REQ-029 With macro WINDOW_ALLOCATOR_OVERRUN_DETECT_EN defined, overrun SHALL set on select=1 while busy=1 and stay set until reset.
REQ-030 Without WINDOW_ALLOCATOR_OVERRUN_DETECT_EN, overrun SHALL be constant 0; all other behaviour is identical.

Verification
REQ-031 Interior window: image_dim=230, padding=1, centre (5,3), all weights=1, rd_ack tied 1, rd_data=10 -> nine reads at addresses 231,232,233,459,460,461,687,688,689, result=90, result_valid at N+10.
REQ-032 Top-left corner: centre (1,1), weights=1, rd_data=7 -> reads only at 0,1,228,229, padded taps take one cycle each, result=28.
REQ-033 Bottom-right corner with signed weights: centre (228,228), weights=-1, rd_data=255 -> reads only at 51754,51755,51982,51983, result=-1020.
REQ-034 Read stall and backpressure: rd_ack withheld 3 cycles on tap 4 -> rd_req and rd_addr stable across the stall; result_ready low 5 cycles -> result_valid and result held, no return to IDLE.
REQ-035 Overrun: select pulsed during FETCH -> operands unchanged, overrun=1 only when the macro is defined; rst mid-FETCH -> IDLE with all outputs 0 on the next cycle.

Source files
------------

// File: rtl/window_allocator.sv
// 3x3 window fetch-and-accumulate engine: reads the non-padded taps around a centre pixel and sums data*weight.
// Optional feature: define WINDOW_ALLOCATOR_OVERRUN_DETECT_EN to enable the sticky overrun flag.
module window_allocator #(
   parameter int ADDR_W = 16,
   parameter int ACC_W  = 21
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    select,
   input  logic [7:0]              center_x,
   input  logic [7:0]              center_y,
   input  logic [7:0]              image_dim,
   input  logic [1:0]              padding,
   input  logic [71:0]             weights,
   output logic                    busy,
   output logic                    rd_req,
   output logic [ADDR_W-1:0]       rd_addr,
   input  logic                    rd_ack,
   input  logic [7:0]              rd_data,
   output logic signed [ACC_W-1:0] result,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic                    overrun
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [7:0]              r_cx, r_cy, r_dim, w_cx_nxt, w_cy_nxt, w_dim_nxt;
   logic [1:0]              r_pad, w_pad_nxt;
   logic [71:0]             r_w, w_w_nxt;
   logic [3:0]              r_tap, w_tap_nxt;
   logic signed [ACC_W-1:0] r_acc, w_acc_nxt, w_acc_add;
   logic signed [ACC_W-1:0] r_result, w_result_nxt;
   logic                    r_busy, r_valid, r_rd_req, w_req_nxt;
   logic [ADDR_W-1:0]       r_rd_addr, w_addr_nxt;
   logic signed [7:0]       w_weight;
   logic signed [16:0]      w_data_ext, w_wt_ext, w_prod;

   function automatic logic [1:0] f_row(input logic [3:0] tap);
      if (tap >= 4'd6) begin
         f_row = 2'd2;
      end else if (tap >= 4'd3) begin
         f_row = 2'd1;
      end else begin
         f_row = 2'd0;
      end
   endfunction

   function automatic logic [1:0] f_col(input logic [3:0] tap);
      logic [1:0] row;
      logic [3:0] diff;
      row  = f_row(tap);
      diff = tap - ({1'b0, row, 1'b0} + {2'b00, row});
      f_col = diff[1:0];
   endfunction

   // 9-bit coordinate so that c-1 at c=0 becomes negative and compares as padded.
   function automatic logic [8:0] f_coord(input logic [7:0] c, input logic [1:0] off);
      f_coord = {1'b0, c} + {7'd0, off} - 9'd1;
   endfunction

   function automatic logic f_out(input logic [8:0] c, input logic [7:0] dim, input logic [1:0] pad);
      logic signed [8:0] lo, hi;
      lo    = $signed({7'd0, pad});
      hi    = $signed({1'b0, dim} - {7'd0, pad});
      f_out = ($signed(c) < lo) || ($signed(c) >= hi);
   endfunction

   function automatic logic f_padded(input logic [7:0] cx, input logic [7:0] cy, input logic [7:0] dim,
                                     input logic [1:0] pad, input logic [3:0] tap);
      f_padded = f_out(f_coord(cx, f_col(tap)), dim, pad) || f_out(f_coord(cy, f_row(tap)), dim, pad);
   endfunction

   function automatic logic [ADDR_W-1:0] f_addr(input logic [7:0] cx, input logic [7:0] cy, input logic [7:0] dim,
                                                input logic [1:0] pad, input logic [3:0] tap);
      logic [8:0]  x, y;
      logic [31:0] lx, ly, lw, la;
      x      = f_coord(cx, f_col(tap));
      y      = f_coord(cy, f_row(tap));
      lx     = {23'd0, x} - {30'd0, pad};
      ly     = {23'd0, y} - {30'd0, pad};
      lw     = {24'd0, dim} - {29'd0, pad, 1'b0};
      la     = ly * lw + lx;
      f_addr = la[ADDR_W-1:0];
   endfunction

   // Next-state, operand latch and accumulate; read request for the upcoming tap is precomputed so rd_req/rd_addr are registered.
   always_comb begin
      w_state_nxt  = r_state;
      w_cx_nxt     = r_cx;
      w_cy_nxt     = r_cy;
      w_dim_nxt    = r_dim;
      w_pad_nxt    = r_pad;
      w_w_nxt      = r_w;
      w_tap_nxt    = r_tap;
      w_acc_nxt    = r_acc;
      w_result_nxt = r_result;
      w_weight     = r_w[{r_tap, 3'b000} +: 8];
      w_data_ext   = {9'd0, rd_data};
      w_wt_ext     = {{9{w_weight[7]}}, w_weight};
      w_prod       = w_data_ext * w_wt_ext;
      w_acc_add    = r_acc + {{(ACC_W-17){w_prod[16]}}, w_prod};
      case (r_state)
         S_IDLE: begin
            if (select) begin
               w_cx_nxt    = center_x;
               w_cy_nxt    = center_y;
               w_dim_nxt   = image_dim;
               w_pad_nxt   = padding;
               w_w_nxt     = weights;
               w_tap_nxt   = 4'd0;
               w_acc_nxt   = {ACC_W{1'b0}};
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_FETCH: begin
            // A tap with no request outstanding is padded and retires unconditionally.
            if (!r_rd_req || rd_ack) begin
               if (r_rd_req) begin
                  w_acc_nxt = w_acc_add;
               end else begin
                  w_acc_nxt = r_acc;
               end
               if (r_tap == 4'd8) begin
                  w_state_nxt  = S_DONE;
                  w_result_nxt = w_acc_nxt;
               end else begin
                  w_tap_nxt = r_tap + 4'd1;
               end
            end else begin
               w_state_nxt = S_FETCH;
            end
         end
         S_DONE: begin
            if (result_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      w_req_nxt = (w_state_nxt == S_FETCH) && !f_padded(w_cx_nxt, w_cy_nxt, w_dim_nxt, w_pad_nxt, w_tap_nxt);
      if (w_req_nxt) begin
         w_addr_nxt = f_addr(w_cx_nxt, w_cy_nxt, w_dim_nxt, w_pad_nxt, w_tap_nxt);
      end else begin
         w_addr_nxt = {ADDR_W{1'b0}};
      end
   end

   // State, operand and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cx      <= 8'd0;
         r_cy      <= 8'd0;
         r_dim     <= 8'd0;
         r_pad     <= 2'd0;
         r_w       <= 72'd0;
         r_tap     <= 4'd0;
         r_acc     <= {ACC_W{1'b0}};
         r_result  <= {ACC_W{1'b0}};
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
         r_rd_req  <= 1'b0;
         r_rd_addr <= {ADDR_W{1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_cx      <= w_cx_nxt;
         r_cy      <= w_cy_nxt;
         r_dim     <= w_dim_nxt;
         r_pad     <= w_pad_nxt;
         r_w       <= w_w_nxt;
         r_tap     <= w_tap_nxt;
         r_acc     <= w_acc_nxt;
         r_result  <= w_result_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
         r_valid   <= (w_state_nxt == S_DONE);
         r_rd_req  <= w_req_nxt;
         r_rd_addr <= w_addr_nxt;
      end
   end

   assign busy         = r_busy;
   assign rd_req       = r_rd_req;
   assign rd_addr      = r_rd_addr;
   assign result       = r_result;
   assign result_valid = r_valid;

`ifdef WINDOW_ALLOCATOR_OVERRUN_DETECT_EN
   logic r_overrun;

   // Sticky flag: a new window was offered while the engine was still working.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (select && r_busy) begin
         r_overrun <= 1'b1;
      end else begin
         r_overrun <= r_overrun;
      end
   end

   assign overrun = r_overrun;
`else
   assign overrun = 1'b0;
`endif

endmodule
